// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO read-side controller.
package fifo_reader_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } fifo_reader_state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: absorbs the FIFO's registered read data while keeping FIFO order.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] ent0_q;
  logic [WIDTH-1:0] ent1_q;
  logic [1:0]       occ_q;
  logic             pop_ok_c;
  logic             push_ok_c;

  // Pops from an empty buffer and pushes into a full one without a pop are ignored.
  assign pop_ok_c  = pop && (occ_q != 2'd0);
  assign push_ok_c = push && ((occ_q != 2'd2) || pop_ok_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push_ok_c, pop_ok_c})
        2'b10: begin
          if (occ_q == 2'd0) ent0_q <= push_data;
          else               ent1_q <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            ent0_q <= push_data;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = ent0_q;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side controller: issues reads, hides read latency behind a skid buffer, streams words out.
// Optional FIFO_READER_CHECKSUM_EN adds rd_checksum, the running XOR of delivered words.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err
`ifdef FIFO_READER_CHECKSUM_EN
  ,
  output logic [FIFO_WIDTH-1:0] rd_checksum
`endif
);

  fifo_reader_state_e state_q;
  fifo_reader_state_e state_d;
  logic               inflight_q;
  logic [1:0]         occ;
  logic [2:0]         fill_c;
  logic               pop_c;

  fifo_reader_skid #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_data_out),
    .pop       (pop_c),
    .head_data (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign pop_c   = m_valid && m_ready;
  assign busy    = (state_q != IDLE);

  // Words already held plus the word in flight; a same-cycle pop frees a slot for a new read.
  assign fill_c     = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_rd_en = (state_q == ACTIVE) && !fifo_empty && ((fill_c < 3'd2) || pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACTIVE;
      ACTIVE:  if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                                state_d = ACTIVE;
        else if ((occ == 2'd0) && !inflight_q)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // In-flight tracking, delivered-word count and sticky underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= 1'b0;
      rd_count      <= '0;
      underflow_err <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (pop_c) rd_count <= rd_count + CNT_WIDTH'(1);
      if (fifo_underflow) underflow_err <= 1'b1;
    end
  end

`ifdef FIFO_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_checksum <= '0;
    else if (pop_c) rd_checksum <= rd_checksum ^ m_data;
  end
`endif

endmodule
